// File: rtl/pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_pkg
// Brief    : Shared constants for the generic MIPS inter-stage pipeline
//            register: depth limit, per-boundary bundle widths and the
//            per-edge priority encoding used by every slice.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_reg_pkg;

    // Upper bound on the number of slices a single pipe_stage_reg may chain.
    localparam int unsigned MAX_DEPTH = 8;

    // Default bundle widths for the four classic MIPS boundaries.
    // IF/ID : PC+4, instruction word
    localparam int unsigned IF_ID_DATA_W  = 64;
    localparam int unsigned IF_ID_CTRL_W  = 1;
    // ID/EX : PC+4, rs data, rt data, sign-extended imm, rt, rd
    localparam int unsigned ID_EX_DATA_W  = 138;
    localparam int unsigned ID_EX_CTRL_W  = 9;
    // EX/MEM: branch target, zero flag, ALU result, store data, dest reg
    localparam int unsigned EX_MEM_DATA_W = 102;
    localparam int unsigned EX_MEM_CTRL_W = 5;
    // MEM/WB: load data, ALU result, dest reg
    localparam int unsigned MEM_WB_DATA_W = 69;
    localparam int unsigned MEM_WB_CTRL_W = 2;

    // Action taken by a slice at a clock edge, highest priority first.
    typedef enum logic [1:0] {
        PR_RESET = 2'd0,
        PR_FLUSH = 2'd1,
        PR_STALL = 2'd2,
        PR_SHIFT = 2'd3
    } pr_sel_e;

    // Resolve the hazard-unit controls into the single action for this edge.
    function automatic pr_sel_e pr_select(input logic reset,
                                          input logic flush,
                                          input logic stall);
        pr_sel_e sel;
        if (reset)      sel = PR_RESET;
        else if (flush) sel = PR_FLUSH;
        else if (stall) sel = PR_STALL;
        else            sel = PR_SHIFT;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_slice.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_slice
// Brief    : One register slice of the pipeline register: a valid bit, an
//            opaque datapath bundle and a control bundle. Control is forced
//            to zero whenever the slice holds a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_slice
    import pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    pr_sel_e           w_sel;
    logic              w_valid_d;
    logic [DATA_W-1:0] w_data_d;
    logic [CTRL_W-1:0] w_ctrl_d;
    logic              r_valid_q;
    logic [DATA_W-1:0] r_data_q;
    logic [CTRL_W-1:0] r_ctrl_q;

    // Next-state selection: flush still advances data so the datapath keeps
    // moving, but marks the entry as a bubble with control squashed.
    always_comb begin
        w_sel     = pr_select(reset, flush_i, stall_i);
        w_valid_d = r_valid_q;
        w_data_d  = r_data_q;
        w_ctrl_d  = r_ctrl_q;
        case (w_sel)
            PR_RESET: begin
                w_valid_d = 1'b0;
                w_data_d  = '0;
                w_ctrl_d  = '0;
            end
            PR_FLUSH: begin
                w_valid_d = 1'b0;
                w_data_d  = data_i;
                w_ctrl_d  = '0;
            end
            PR_STALL: begin
                w_valid_d = r_valid_q;
                w_data_d  = r_data_q;
                w_ctrl_d  = r_ctrl_q;
            end
            PR_SHIFT: begin
                w_valid_d = valid_i;
                w_data_d  = data_i;
                w_ctrl_d  = ctrl_i & {CTRL_W{valid_i}};
            end
            default: begin
                w_valid_d = r_valid_q;
                w_data_d  = r_data_q;
                w_ctrl_d  = r_ctrl_q;
            end
        endcase
    end

    // Slice state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_ctrl_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
            r_ctrl_q  <= w_ctrl_d;
        end
    end

    assign valid_o = r_valid_q;
    assign data_o  = r_data_q;
    assign ctrl_o  = r_ctrl_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Parametrised inter-stage pipeline register. Chains DEPTH slices
//            (legal range 1..MAX_DEPTH) sharing one stall and one flush from
//            the hazard unit. All outputs come straight from flops.
//            Optional macro PIPE_REG_PERF_EN adds saturating stall/flush
//            cycle counters and their clear input.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
`ifdef PIPE_REG_PERF_EN
    input  logic              perf_clr_in,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctrl_out
);

    // Chain taps: index 0 is the stage input, index k is slice k-1 output.
    logic              w_valid [0:DEPTH];
    logic [DATA_W-1:0] w_data  [0:DEPTH];
    logic [CTRL_W-1:0] w_ctrl  [0:DEPTH];

    assign w_valid[0] = valid_in;
    assign w_data[0]  = data_in;
    assign w_ctrl[0]  = ctrl_in;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        pipe_stage_slice #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_slice (
            .clk     (clk),
            .reset   (reset),
            .stall_i (stall_in),
            .flush_i (flush_in),
            .valid_i (w_valid[k]),
            .data_i  (w_data[k]),
            .ctrl_i  (w_ctrl[k]),
            .valid_o (w_valid[k+1]),
            .data_o  (w_data[k+1]),
            .ctrl_o  (w_ctrl[k+1])
        );
    end

    assign valid_out = w_valid[DEPTH];
    assign data_out  = w_data[DEPTH];
    assign ctrl_out  = w_ctrl[DEPTH];

`ifdef PIPE_REG_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pr_sel_e          w_cnt_sel;
    logic [CNT_W-1:0] w_stall_cnt_d;
    logic [CNT_W-1:0] w_flush_cnt_d;
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] r_flush_cnt_q;

    // Counters follow the same edge action the slices take; clear beats
    // increment and both stop at all-ones instead of wrapping.
    always_comb begin
        w_cnt_sel     = pr_select(reset, flush_in, stall_in);
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (perf_clr_in) begin
            w_stall_cnt_d = '0;
            w_flush_cnt_d = '0;
        end else begin
            if (w_cnt_sel == PR_STALL && r_stall_cnt_q != CNT_MAX)
                w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
            if (w_cnt_sel == PR_FLUSH && r_flush_cnt_q != CNT_MAX)
                w_flush_cnt_d = r_flush_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;
`else
    // Counter width only matters when the counters are built.
    if (CNT_W > 0) begin : g_no_perf
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Directed self-checking bench for pipe_stage_reg with DEPTH=2,
//            DATA_W=32, CTRL_W=4, CNT_W=3. Counter scenarios are compiled
//            only when PIPE_REG_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 3;

    logic              clk;
    logic              reset;
    logic              stall_in;
    logic              flush_in;
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctrl_out;
`ifdef PIPE_REG_PERF_EN
    logic              perf_clr_in;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_in    (stall_in),
        .flush_in    (flush_in),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ctrl_in     (ctrl_in),
`ifdef PIPE_REG_PERF_EN
        .perf_clr_in (perf_clr_in),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .valid_out   (valid_out),
        .data_out    (data_out),
        .ctrl_out    (ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_in = 1'b0;
        flush_in = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        ctrl_in  = '0;
    endtask

`ifdef PIPE_REG_PERF_EN
    task automatic clear_counters();
        idle_inputs();
        perf_clr_in = 1'b1;
        step();
        perf_clr_in = 1'b0;
    endtask
`endif

    task automatic test_reset();
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 32'hAAAA_AAAA;
        ctrl_in  = 4'hF;
        step();
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_out); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
        checks++; if (ctrl_out !== 4'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", ctrl_out); end
`ifdef PIPE_REG_PERF_EN
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        checks++; if (flush_cnt !== 3'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
`endif
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] din [4];
        din = '{32'h11, 32'h22, 32'h33, 32'h0};
        for (int i = 0; i < 4; i++) begin
            valid_in = (i < 3);
            ctrl_in  = (i < 3) ? 4'h5 : 4'h0;
            data_in  = din[i];
            step();
            if (i >= 1) begin
                checks++; if (data_out !== din[i-1]) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", i, data_out, din[i-1]); end
                checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, valid_out); end
                checks++; if (ctrl_out !== 4'h5) begin errors++; $display("FAIL stream_ctrl[%0d]: got %h want 5", i, ctrl_out); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
`ifdef PIPE_REG_PERF_EN
        clear_counters();
`endif
        valid_in = 1'b1;
        ctrl_in  = 4'h5;
        data_in  = 32'h11;
        step();
        data_in  = 32'h22;
        step();
        checks++; if (data_out !== 32'h11) begin errors++; $display("FAIL stall_pre: got %h want 11", data_out); end
        stall_in = 1'b1;
        data_in  = 32'h33;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (data_out !== 32'h11) begin errors++; $display("FAIL stall_hold_data[%0d]: got %h want 11", i, data_out); end
            checks++; if (valid_out !== 1'b1 || ctrl_out !== 4'h5) begin errors++; $display("FAIL stall_hold_vc[%0d]: got v=%0b c=%h want v=1 c=5", i, valid_out, ctrl_out); end
        end
        stall_in = 1'b0;
        step();
        checks++; if (data_out !== 32'h22) begin errors++; $display("FAIL stall_post1: got %h want 22", data_out); end
        idle_inputs();
        step();
        checks++; if (data_out !== 32'h33 || valid_out !== 1'b1 || ctrl_out !== 4'h5) begin errors++; $display("FAIL stall_post2: got d=%h v=%0b c=%h want d=33 v=1 c=5", data_out, valid_out, ctrl_out); end
`ifdef PIPE_REG_PERF_EN
        checks++; if (stall_cnt !== 3'd3) begin errors++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
        checks++; if (flush_cnt !== 3'd0) begin errors++; $display("FAIL stall_flush_cnt: got %0d want 0", flush_cnt); end
`endif
    endtask

    task automatic test_flush_stall();
`ifdef PIPE_REG_PERF_EN
        clear_counters();
`endif
        valid_in = 1'b1;
        ctrl_in  = 4'hA;
        data_in  = 32'h44;
        step();
        data_in  = 32'h55;
        step();
        checks++; if (data_out !== 32'h44 || valid_out !== 1'b1 || ctrl_out !== 4'hA) begin errors++; $display("FAIL flush_pre: got d=%h v=%0b c=%h want d=44 v=1 c=a", data_out, valid_out, ctrl_out); end
        flush_in = 1'b1;
        stall_in = 1'b1;
        data_in  = 32'h66;
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid1: got %0b want 0", valid_out); end
        checks++; if (ctrl_out !== 4'h0) begin errors++; $display("FAIL flush_ctrl1: got %h want 0", ctrl_out); end
        checks++; if (data_out !== 32'h55) begin errors++; $display("FAIL flush_data1: got %h want 55", data_out); end
        idle_inputs();
        step();
        checks++; if (valid_out !== 1'b0 || ctrl_out !== 4'h0) begin errors++; $display("FAIL flush_bubble2: got v=%0b c=%h want v=0 c=0", valid_out, ctrl_out); end
        checks++; if (data_out !== 32'h66) begin errors++; $display("FAIL flush_data2: got %h want 66", data_out); end
`ifdef PIPE_REG_PERF_EN
        checks++; if (flush_cnt !== 3'd1) begin errors++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt); end
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL flush_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    endtask

    task automatic test_gating();
        valid_in = 1'b0;
        ctrl_in  = 4'hF;
        data_in  = 32'h77;
        step();
        valid_in = 1'b1;
        ctrl_in  = 4'h3;
        data_in  = 32'h78;
        step();
        checks++; if (valid_out !== 1'b0 || ctrl_out !== 4'h0) begin errors++; $display("FAIL gate_vc: got v=%0b c=%h want v=0 c=0", valid_out, ctrl_out); end
        checks++; if (data_out !== 32'h77) begin errors++; $display("FAIL gate_data: got %h want 77", data_out); end
        idle_inputs();
        step();
        checks++; if (data_out !== 32'h78 || valid_out !== 1'b1 || ctrl_out !== 4'h3) begin errors++; $display("FAIL gate_next: got d=%h v=%0b c=%h want d=78 v=1 c=3", data_out, valid_out, ctrl_out); end
    endtask

    task automatic test_reset_mid_stall();
        valid_in = 1'b1;
        ctrl_in  = 4'h9;
        data_in  = 32'h99;
        step();
        data_in  = 32'h9A;
        step();
        stall_in = 1'b1;
        step();
        checks++; if (data_out !== 32'h99 || valid_out !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got d=%h v=%0b want d=99 v=1", data_out, valid_out); end
        reset    = 1'b1;
        flush_in = 1'b1;
`ifdef PIPE_REG_PERF_EN
        perf_clr_in = 1'b1;
`endif
        step();
        checks++; if (valid_out !== 1'b0 || ctrl_out !== 4'h0 || data_out !== 32'h0) begin errors++; $display("FAIL rst_mid_clear: got d=%h v=%0b c=%h want all 0", data_out, valid_out, ctrl_out); end
        reset = 1'b0;
`ifdef PIPE_REG_PERF_EN
        perf_clr_in = 1'b0;
`endif
        idle_inputs();
        valid_in = 1'b1;
        ctrl_in  = 4'h6;
        data_in  = 32'hBB;
        step();
        checks++; if (valid_out !== 1'b0 || data_out !== 32'h0) begin errors++; $display("FAIL rst_mid_first: got d=%h v=%0b want d=0 v=0", data_out, valid_out); end
        data_in = 32'hCC;
        step();
        checks++; if (data_out !== 32'hBB || valid_out !== 1'b1 || ctrl_out !== 4'h6) begin errors++; $display("FAIL rst_mid_second: got d=%h v=%0b c=%h want d=bb v=1 c=6", data_out, valid_out, ctrl_out); end
`ifdef PIPE_REG_PERF_EN
        checks++; if (stall_cnt !== 3'd0 || flush_cnt !== 3'd0) begin errors++; $display("FAIL rst_mid_cnt: got s=%0d f=%0d want 0 0", stall_cnt, flush_cnt); end
`endif
        idle_inputs();
    endtask

`ifdef PIPE_REG_PERF_EN
    task automatic test_saturation();
        clear_counters();
        stall_in = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 6) begin
                checks++; if (stall_cnt !== 3'd6) begin errors++; $display("FAIL sat_cnt6: got %0d want 6", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt9: got %0d want 7", stall_cnt); end
        perf_clr_in = 1'b1;
        step();
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL sat_clr: got %0d want 0", stall_cnt); end
        perf_clr_in = 1'b0;
        step();
        checks++; if (stall_cnt !== 3'd1) begin errors++; $display("FAIL sat_restart: got %0d want 1", stall_cnt); end
        idle_inputs();
    endtask
`endif

    initial begin
        reset    = 1'b1;
        idle_inputs();
`ifdef PIPE_REG_PERF_EN
        perf_clr_in = 1'b0;
`endif
        test_reset();
        test_stream();
        test_stall();
        test_flush_stall();
        test_gating();
        test_reset_mid_stall();
`ifdef PIPE_REG_PERF_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
